polar_encoder_seq: RTL and testbench

- Sequential polar encoder, the transmit-side counterpart of the SC decoder processing-element chain.
- Builds the N-bit input vector u from a serial stream of information bits, inserting 0 at every frozen position of a per-block frozen mask.
- Computes x = u·F^⊗n, F=[[1,0],[1,1]], with one in-place XOR butterfly stage per cycle.
- Presents the codeword in parallel with a valid/ready handshake. Its output is the reference codeword for the decoder testbenches.

---
 rtl/polar_pkg.sv | 27 ++
 rtl/polar_encoder_seq_if.sv | 24 ++
 rtl/polar_encoder_seq.sv | 118 +++++++++++
 tb/tb_polar_encoder_seq.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/polar_pkg.sv
// Shared definitions for the sequential polar encoder and the decoder reference models.
// butterfly_stage works on a MAX_N-wide vector so any legal block length can reuse it.
package polar_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      ENCODE = 2'd2,
      DONE   = 2'd3
   } enc_state_e;

   localparam int MAX_N = 1024;

   // Bits at positions >= N stay zero because j | 2^s < N whenever j < N and 2^s < N.
   function automatic logic [MAX_N-1:0] butterfly_stage(input logic [MAX_N-1:0] v,
                                                        input int unsigned      s);
      logic [MAX_N-1:0] r;
      r = v;
      for (int j = 0; j < MAX_N; j++) begin
         if (((j >> s) & 1) == 0) begin
            r[j] = v[j] ^ v[j | (1 << s)];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/polar_encoder_seq_if.sv
// Block-control, info-bit stream and codeword handshake of the polar encoder.
interface polar_encoder_seq_if #(
   parameter int N = 32
);
   logic         start_i;
   logic [N-1:0] frozen_mask_i;
   logic         busy_o;
   logic         info_valid_i;
   logic         info_bit_i;
   logic         info_ready_o;
   logic         cw_valid_o;
   logic         cw_ready_i;
   logic [N-1:0] cw_o;

   modport master (
      output start_i, frozen_mask_i, info_valid_i, info_bit_i, cw_ready_i,
      input  busy_o, info_ready_o, cw_valid_o, cw_o
   );

   modport slave (
      input  start_i, frozen_mask_i, info_valid_i, info_bit_i, cw_ready_i,
      output busy_o, info_ready_o, cw_valid_o, cw_o
   );
endinterface

// File: rtl/polar_encoder_seq.sv
// Sequential polar encoder: fills u from a serial info stream around a frozen mask,
// then runs one in-place XOR butterfly stage per cycle and presents x = u*F^(xn).
module polar_encoder_seq
   import polar_pkg::*;
#(
   parameter  int N     = 32,
   localparam int LOG2N = $clog2(N)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   polar_encoder_seq_if.slave  bus
);

   localparam int IDXW = LOG2N;
   localparam int SW   = (LOG2N > 1) ? $clog2(LOG2N) : 1;
   localparam logic [IDXW-1:0] IDX_ONE   = IDXW'(1);
   localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(N - 1);
   localparam logic [SW-1:0]   STG_ONE   = SW'(1);
   localparam logic [SW-1:0]   STG_LAST  = SW'(LOG2N - 1);

   enc_state_e       state_r;
   logic [IDXW-1:0]  idx_r;
   logic [SW-1:0]    stage_r;
   logic [N-1:0]     mask_r;
   logic [N-1:0]     v_r;
   logic             busy_r;
   logic             cw_valid_r;
   logic             info_ready_s;
   logic [MAX_N-1:0] v_ext_s;
   logic [MAX_N-1:0] bfly_full_s;
   logic [N-1:0]     bfly_s;

   // Widen the vector, apply the current butterfly stage, keep the low N bits.
   always_comb begin
      v_ext_s          = '0;
      v_ext_s[N-1:0]   = v_r;
      bfly_full_s      = butterfly_stage(v_ext_s, {{(32-SW){1'b0}}, stage_r});
      bfly_s           = bfly_full_s[N-1:0];
   end

   generate
      if (N < MAX_N) begin : g_unused
         logic unused_s;
         assign unused_s = ^bfly_full_s[MAX_N-1:N];
      end
   endgenerate

   // Ready depends only on state, position and mask, never on info_valid_i.
   always_comb begin
      if ((state_r == FILL) && !mask_r[idx_r]) begin
         info_ready_s = 1'b1;
      end else begin
         info_ready_s = 1'b0;
      end
   end

   // Block FSM with fill/encode counters, vector register and registered status outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r    <= IDLE;
         idx_r      <= '0;
         stage_r    <= '0;
         mask_r     <= '0;
         v_r        <= '0;
         busy_r     <= 1'b0;
         cw_valid_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.start_i) begin
                  mask_r  <= bus.frozen_mask_i;
                  idx_r   <= '0;
                  busy_r  <= 1'b1;
                  state_r <= FILL;
               end
            end
            FILL: begin
               if (mask_r[idx_r] || bus.info_valid_i) begin
                  v_r[idx_r] <= mask_r[idx_r] ? 1'b0 : bus.info_bit_i;
                  if (idx_r == IDX_LAST) begin
                     stage_r <= '0;
                     state_r <= ENCODE;
                  end else begin
                     idx_r <= idx_r + IDX_ONE;
                  end
               end
            end
            ENCODE: begin
               v_r <= bfly_s;
               if (stage_r == STG_LAST) begin
                  cw_valid_r <= 1'b1;
                  state_r    <= DONE;
               end else begin
                  stage_r <= stage_r + STG_ONE;
               end
            end
            DONE: begin
               if (bus.cw_ready_i) begin
                  cw_valid_r <= 1'b0;
                  busy_r     <= 1'b0;
                  state_r    <= IDLE;
               end
            end
            default: begin
               state_r    <= IDLE;
               busy_r     <= 1'b0;
               cw_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy_o       = busy_r;
   assign bus.info_ready_o = info_ready_s;
   assign bus.cw_valid_o   = cw_valid_r;
   assign bus.cw_o         = v_r;

endmodule

// File: tb/tb_polar_encoder_seq.sv
// Randomized scoreboard bench for polar_encoder_seq (N=8) with a subset-XOR reference model.
module tb_polar_encoder_seq;

   localparam int N     = 8;
   localparam int LOG2N = 3;

   typedef struct {
      logic [N-1:0] cw;
      int           cyc;
      int           rdy;
   } exp_t;

   logic clk    = 1'b0;
   logic rst_ni = 1'b0;
   int   cycle  = 0;
   int   checks = 0;
   int   errors = 0;

   exp_t exp_q[$];
   bit   info_q[$];
   int   stall_q[$];

   polar_encoder_seq_if #(.N(N)) bus();

   polar_encoder_seq #(.N(N)) dut (
      .clk_i  (clk),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cycle);
      end
   endtask

   // x_j is the XOR of every u_i whose index i contains all bits of j.
   function automatic logic [N-1:0] ref_cw(input logic [N-1:0] mask, input bit bits[$]);
      logic [N-1:0] u;
      logic [N-1:0] x;
      int k;
      u = '0;
      x = '0;
      k = 0;
      for (int i = 0; i < N; i++) begin
         if (!mask[i]) begin
            u[i] = bits[k];
            k++;
         end
      end
      for (int j = 0; j < N; j++)
         for (int i = 0; i < N; i++)
            if ((i & j) == j) x[j] = x[j] ^ u[i];
      return x;
   endfunction

   task automatic start_block(input logic [N-1:0] mask, input bit push,
                              input int glitch_at, output int sc);
      int   k;
      int   rem;
      int   t;
      int   stalls;
      bit   rdy;
      exp_t e;
      k = 0;
      t = 0;
      stalls = 0;
      while (bus.busy_o && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      check("idle_before_start", {31'd0, bus.busy_o}, 32'd0);
      bus.start_i       = 1'b1;
      bus.frozen_mask_i = mask;
      @(posedge clk); #1;
      sc                = cycle;
      bus.start_i       = 1'b0;
      bus.frozen_mask_i = N'($urandom);
      check("busy_after_start", {31'd0, bus.busy_o}, 32'd1);
      foreach (stall_q[i]) stalls += stall_q[i];
      if (push) begin
         e.cw  = ref_cw(mask, info_q);
         e.cyc = sc + N + LOG2N + stalls;
         e.rdy = info_q.size() + stalls;
         exp_q.push_back(e);
      end
      rem = (stall_q.size() > 0) ? stall_q[0] : 0;
      t   = 0;
      while (k < info_q.size() && t < 200) begin
         bus.info_valid_i = (rem == 0);
         bus.info_bit_i   = info_q[k];
         bus.start_i      = (t == glitch_at);
         if (t == glitch_at) bus.frozen_mask_i = '0;
         rdy = bus.info_ready_o;
         @(posedge clk); #1;
         t++;
         if (rdy) begin
            if (rem > 0) rem--;
            else begin
               k++;
               rem = (k < stall_q.size()) ? stall_q[k] : 0;
            end
         end
      end
      bus.info_valid_i = 1'b0;
      bus.start_i      = 1'b0;
      check("feed_complete", k, info_q.size());
   endtask

   task automatic finish_block(input int bp);
      int t;
      t = 0;
      while (!bus.cw_valid_o && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      check("cw_valid_seen", {31'd0, bus.cw_valid_o}, 32'd1);
      repeat (bp) begin
         @(posedge clk); #1;
      end
      bus.cw_ready_i = 1'b1;
      @(posedge clk); #1;
      bus.cw_ready_i = 1'b0;
   endtask

   // Monitor: pops the scoreboard on each new codeword and polices the DONE handshake.
   initial begin : monitor
      exp_t         e;
      logic [N-1:0] held;
      bit           pv;
      bit           phs;
      int           rc;
      pv   = 1'b0;
      phs  = 1'b0;
      rc   = 0;
      held = '0;
      forever begin
         @(negedge clk);
         if (!rst_ni) begin
            pv  = 1'b0;
            phs = 1'b0;
            rc  = 0;
         end else begin
            if (phs) begin
               check("idle_after_handshake", {30'd0, bus.busy_o, bus.cw_valid_o}, 32'd0);
            end else if (pv) begin
               check("cw_valid_held", {31'd0, bus.cw_valid_o}, 32'd1);
               check("cw_stable", {24'd0, bus.cw_o}, {24'd0, held});
            end else if (bus.cw_valid_o) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_cw: got 0x%0h, expected no codeword (cycle %0d)",
                           bus.cw_o, cycle);
               end else begin
                  e = exp_q.pop_front();
                  check("cw_value", {24'd0, bus.cw_o}, {24'd0, e.cw});
                  check("cw_latency", cycle, e.cyc);
                  check("info_ready_cycles", rc, e.rdy);
               end
               held = bus.cw_o;
               rc   = 0;
            end
            if (bus.info_ready_o) rc++;
            phs = bus.cw_valid_o && bus.cw_ready_i;
            pv  = bus.cw_valid_o;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected normal end");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int sc;
      int nb;
      logic [N-1:0] m;
      bus.start_i       = 1'b0;
      bus.frozen_mask_i = '0;
      bus.info_valid_i  = 1'b0;
      bus.info_bit_i    = 1'b0;
      bus.cw_ready_i    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", {31'd0, bus.busy_o}, 32'd0);
      check("rst_cw_valid", {31'd0, bus.cw_valid_o}, 32'd0);
      check("rst_info_ready", {31'd0, bus.info_ready_o}, 32'd0);
      check("rst_cw", {24'd0, bus.cw_o}, 32'd0);
      rst_ni = 1'b1;
      @(posedge clk); #1;

      // All frozen: no handshakes, zero codeword.
      info_q.delete(); stall_q.delete();
      start_block(8'hFF, 1'b1, -1, sc); finish_block(0);
      // Single info bit at idx 7 with long backpressure.
      info_q = '{1'b1}; stall_q = '{0};
      start_block(8'h7F, 1'b1, -1, sc); finish_block(5);
      info_q = '{1'b1}; stall_q = '{0};
      start_block(8'hFE, 1'b1, -1, sc); finish_block(0);
      // Stall before second bit, plus an ignored mid-FILL start.
      info_q = '{1'b1, 1'b0, 1'b1, 1'b1}; stall_q = '{0, 2, 0, 0};
      start_block(8'h17, 1'b1, 3, sc); finish_block(1);
      // All info positions.
      info_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}; stall_q = '{1, 0, 0, 0, 0, 0, 0, 2};
      start_block(8'h00, 1'b1, -1, sc); finish_block(2);

      // Reset in ENCODE stage 1 abandons the block.
      info_q = '{1'b1}; stall_q = '{0};
      start_block(8'hFE, 1'b0, -1, sc);
      while (cycle < sc + N + 1) begin
         @(posedge clk); #1;
      end
      rst_ni = 1'b0;
      #1;
      check("midrst_busy", {31'd0, bus.busy_o}, 32'd0);
      check("midrst_cw_valid", {31'd0, bus.cw_valid_o}, 32'd0);
      check("midrst_cw", {24'd0, bus.cw_o}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      rst_ni = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("midrst_no_restart", {31'd0, bus.busy_o}, 32'd0);
      info_q = '{1'b1}; stall_q = '{0};
      start_block(8'hFE, 1'b1, -1, sc); finish_block(0);

      for (int b = 0; b < 25; b++) begin
         m = N'($urandom);
         info_q.delete(); stall_q.delete();
         nb = 0;
         for (int i = 0; i < N; i++) if (!m[i]) nb++;
         for (int i = 0; i < nb; i++) begin
            info_q.push_back(1'($urandom_range(0, 1)));
            stall_q.push_back(int'($urandom_range(0, 2)));
         end
         start_block(m, 1'b1, int'($urandom_range(0, 6)), sc);
         finish_block(int'($urandom_range(0, 3)));
      end

      repeat (5) @(posedge clk);
      #1;
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
